// File: rtl/eth_sb_pkg.sv
// Shared types and constants for the Ethernet sideband APB front-end.
package eth_sb_pkg;

   localparam int STRB_WIDTH         = 4;
   localparam int ETH_SB_ADDR_WIDTH  = 32;
   localparam int ETH_SB_DATA_WIDTH  = 32;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WR_REQ  = 3'd1,
      RD_REQ  = 3'd2,
      WR_WAIT = 3'd3,
      RD_WAIT = 3'd4,
      RESP    = 3'd5
   } eth_sb_apb_state_e;

endpackage

// File: rtl/eth_sb_apb_fsm_if.sv
// APB slave bus plus sideband controller request/response signals.
interface eth_sb_apb_fsm_if
   import eth_sb_pkg::*;
#(
   parameter int ADDR_WIDTH = ETH_SB_ADDR_WIDTH,
   parameter int DATA_WIDTH = ETH_SB_DATA_WIDTH
);
   logic                   i_eth_sb_psel;
   logic                   i_eth_sb_penable;
   logic                   i_eth_sb_pwrite;
   logic [ADDR_WIDTH-1:0]  i_eth_sb_paddr;
   logic [DATA_WIDTH-1:0]  i_eth_sb_pwdata;
   logic [STRB_WIDTH-1:0]  i_eth_sb_pstrb;
   logic                   o_eth_sb_pready;
   logic                   o_eth_sb_pslverr;
   logic [DATA_WIDTH-1:0]  o_eth_sb_prdata;

   logic [DATA_WIDTH-1:0]  o_eth_sb_ctrl_wdata;
   logic [ADDR_WIDTH-1:0]  o_eth_sb_ctrl_addr;
   logic                   o_eth_sb_ctrl_wr_en;
   logic                   o_eth_sb_ctrl_rd_en;
   logic [STRB_WIDTH-1:0]  o_eth_sb_ctrl_pstrb;
   logic [DATA_WIDTH-1:0]  i_eth_sb_ctrl_rdata;
   logic                   i_eth_sb_ctrl_slverr;
   logic                   i_eth_sb_ctrl_inv_addr;
   logic                   wdata_resp;
   logic                   rdata_resp;
   logic                   fuse_enable;
   logic                   fifo_full;
   logic                   fifo_empty;

   modport slave (
      input  i_eth_sb_psel, i_eth_sb_penable, i_eth_sb_pwrite,
      input  i_eth_sb_paddr, i_eth_sb_pwdata, i_eth_sb_pstrb,
      output o_eth_sb_pready, o_eth_sb_pslverr, o_eth_sb_prdata,
      output o_eth_sb_ctrl_wdata, o_eth_sb_ctrl_addr, o_eth_sb_ctrl_wr_en,
      output o_eth_sb_ctrl_rd_en, o_eth_sb_ctrl_pstrb,
      input  i_eth_sb_ctrl_rdata, i_eth_sb_ctrl_slverr, i_eth_sb_ctrl_inv_addr,
      input  wdata_resp, rdata_resp, fuse_enable, fifo_full, fifo_empty
   );

   modport master (
      output i_eth_sb_psel, i_eth_sb_penable, i_eth_sb_pwrite,
      output i_eth_sb_paddr, i_eth_sb_pwdata, i_eth_sb_pstrb,
      input  o_eth_sb_pready, o_eth_sb_pslverr, o_eth_sb_prdata,
      input  o_eth_sb_ctrl_wdata, o_eth_sb_ctrl_addr, o_eth_sb_ctrl_wr_en,
      input  o_eth_sb_ctrl_rd_en, o_eth_sb_ctrl_pstrb,
      output i_eth_sb_ctrl_rdata, i_eth_sb_ctrl_slverr, i_eth_sb_ctrl_inv_addr,
      output wdata_resp, rdata_resp, fuse_enable, fifo_full, fifo_empty
   );
endinterface

// File: rtl/eth_sb_apb_fsm.sv
// APB slave front-end: turns APB transfers into one-cycle sideband requests
// and completes them on controller response, error or timeout.
//
// state   | meaning
// IDLE    | waiting for psel; fuse/FIFO checks on first psel cycle
// WR_REQ  | ctrl_wr_en pulse
// RD_REQ  | ctrl_rd_en pulse
// WR_WAIT | waiting for wdata_resp or timeout
// RD_WAIT | waiting for rdata_resp or timeout
// RESP    | pready=1 until APB completion or psel drop
module eth_sb_apb_fsm
   import eth_sb_pkg::*;
#(
   parameter int ADDR_WIDTH     = ETH_SB_ADDR_WIDTH,
   parameter int DATA_WIDTH     = ETH_SB_DATA_WIDTH,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic             i_clk,
   input  logic             i_reset,
   eth_sb_apb_fsm_if.slave  bus
);

   localparam logic [2:0] ST_IDLE    = IDLE;
   localparam logic [2:0] ST_WR_REQ  = WR_REQ;
   localparam logic [2:0] ST_RD_REQ  = RD_REQ;
   localparam logic [2:0] ST_WR_WAIT = WR_WAIT;
   localparam logic [2:0] ST_RD_WAIT = RD_WAIT;
   localparam logic [2:0] ST_RESP    = RESP;

   localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [2:0]            state_q, state_d;
   logic                  err_q, err_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [STRB_WIDTH-1:0] strb_q, strb_d;
   logic                  wr_en_q, rd_en_q, pready_q, pslverr_q;
   logic                  resp_seen;

   always_comb begin
      state_d   = state_q;
      err_d     = err_q;
      cnt_d     = '0;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      strb_d    = strb_q;
      resp_seen = (state_q == ST_WR_WAIT) ? bus.wdata_resp : bus.rdata_resp;

      case (state_q)
         ST_IDLE: begin
            err_d = 1'b0;
            if (bus.i_eth_sb_psel) begin
               if (!bus.fuse_enable) begin
                  state_d = ST_RESP;
                  err_d   = 1'b1;
               end else if (bus.i_eth_sb_pwrite && !bus.fifo_full) begin
                  addr_d  = bus.i_eth_sb_paddr;
                  wdata_d = bus.i_eth_sb_pwdata;
                  strb_d  = bus.i_eth_sb_pstrb;
                  state_d = ST_WR_REQ;
               end else if (!bus.i_eth_sb_pwrite && !bus.fifo_empty) begin
                  addr_d  = bus.i_eth_sb_paddr;
                  state_d = ST_RD_REQ;
               end
            end
         end
         ST_WR_REQ: state_d = ST_WR_WAIT;
         ST_RD_REQ: state_d = ST_RD_WAIT;
         ST_WR_WAIT, ST_RD_WAIT: begin
            err_d = err_q | bus.i_eth_sb_ctrl_slverr | bus.i_eth_sb_ctrl_inv_addr;
            // a response arriving on the timeout cycle takes priority
            if (resp_seen) begin
               state_d = ST_RESP;
            end else if (cnt_q == CNT_LAST) begin
               state_d = ST_RESP;
               err_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_RESP: begin
            if (!bus.i_eth_sb_psel || bus.i_eth_sb_penable) begin
               state_d = ST_IDLE;
               err_d   = 1'b0;
            end
         end
         default: begin
            state_d = ST_IDLE;
            err_d   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q   <= ST_IDLE;
         err_q     <= 1'b0;
         cnt_q     <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
         strb_q    <= '0;
         wr_en_q   <= 1'b0;
         rd_en_q   <= 1'b0;
         pready_q  <= 1'b0;
         pslverr_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         err_q     <= err_d;
         cnt_q     <= cnt_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         strb_q    <= strb_d;
         wr_en_q   <= (state_d == ST_WR_REQ);
         rd_en_q   <= (state_d == ST_RD_REQ);
         pready_q  <= (state_d == ST_RESP);
         pslverr_q <= (state_d == ST_RESP) && err_d;
      end
   end

   assign bus.o_eth_sb_pready     = pready_q;
   assign bus.o_eth_sb_pslverr    = pslverr_q;
   assign bus.o_eth_sb_prdata     = bus.i_eth_sb_ctrl_rdata;
   assign bus.o_eth_sb_ctrl_wdata = wdata_q;
   assign bus.o_eth_sb_ctrl_addr  = addr_q;
   assign bus.o_eth_sb_ctrl_wr_en = wr_en_q;
   assign bus.o_eth_sb_ctrl_rd_en = rd_en_q;
   assign bus.o_eth_sb_ctrl_pstrb = strb_q;

endmodule

// File: tb/tb_eth_sb_apb_fsm.sv
// Directed self-checking bench for eth_sb_apb_fsm.
module tb_eth_sb_apb_fsm;

   logic clk;
   logic rst;
   int   checks;
   int   failures;

   eth_sb_apb_fsm_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

   eth_sb_apb_fsm #(
      .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(256)
   ) dut (
      .i_clk   (clk),
      .i_reset (rst),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.i_eth_sb_psel          = 1'b0;
      bus.i_eth_sb_penable       = 1'b0;
      bus.i_eth_sb_pwrite        = 1'b0;
      bus.i_eth_sb_paddr         = '0;
      bus.i_eth_sb_pwdata        = '0;
      bus.i_eth_sb_pstrb         = '0;
      bus.i_eth_sb_ctrl_rdata    = '0;
      bus.i_eth_sb_ctrl_slverr   = 1'b0;
      bus.i_eth_sb_ctrl_inv_addr = 1'b0;
      bus.wdata_resp             = 1'b0;
      bus.rdata_resp             = 1'b0;
      bus.fuse_enable            = 1'b1;
      bus.fifo_full              = 1'b0;
      bus.fifo_empty             = 1'b0;
   endtask

   task automatic start_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      bus.i_eth_sb_psel    = 1'b1;
      bus.i_eth_sb_penable = 1'b1;
      bus.i_eth_sb_pwrite  = 1'b1;
      bus.i_eth_sb_paddr   = a;
      bus.i_eth_sb_pwdata  = d;
      bus.i_eth_sb_pstrb   = s;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #1;
      checks++; if (bus.o_eth_sb_pready !== 1'b0) begin failures++; $display("FAIL reset_pready got=%b exp=0", bus.o_eth_sb_pready); end
      checks++; if (bus.o_eth_sb_pslverr !== 1'b0) begin failures++; $display("FAIL reset_pslverr got=%b exp=0", bus.o_eth_sb_pslverr); end
      checks++; if (bus.o_eth_sb_ctrl_wr_en !== 1'b0 || bus.o_eth_sb_ctrl_rd_en !== 1'b0) begin failures++; $display("FAIL reset_en got=%b%b exp=00", bus.o_eth_sb_ctrl_wr_en, bus.o_eth_sb_ctrl_rd_en); end
      checks++; if (bus.o_eth_sb_ctrl_addr !== 32'h0 || bus.o_eth_sb_ctrl_wdata !== 32'h0 || bus.o_eth_sb_ctrl_pstrb !== 4'h0) begin failures++; $display("FAIL reset_latches got=%h/%h/%h exp=0", bus.o_eth_sb_ctrl_addr, bus.o_eth_sb_ctrl_wdata, bus.o_eth_sb_ctrl_pstrb); end
      tick(); tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic test_write();
      start_write(32'hAABBCCDD, 32'h12345678, 4'hF);
      tick();
      checks++; if (bus.o_eth_sb_ctrl_wr_en !== 1'b1) begin failures++; $display("FAIL wr_en_pulse got=%b exp=1", bus.o_eth_sb_ctrl_wr_en); end
      checks++; if (bus.o_eth_sb_ctrl_addr !== 32'hAABBCCDD) begin failures++; $display("FAIL wr_addr got=%h exp=aabbccdd", bus.o_eth_sb_ctrl_addr); end
      checks++; if (bus.o_eth_sb_ctrl_wdata !== 32'h12345678) begin failures++; $display("FAIL wr_wdata got=%h exp=12345678", bus.o_eth_sb_ctrl_wdata); end
      checks++; if (bus.o_eth_sb_ctrl_pstrb !== 4'hF) begin failures++; $display("FAIL wr_pstrb got=%h exp=f", bus.o_eth_sb_ctrl_pstrb); end
      checks++; if (bus.o_eth_sb_pready !== 1'b0) begin failures++; $display("FAIL wr_req_pready got=%b exp=0", bus.o_eth_sb_pready); end
      tick();
      checks++; if (bus.o_eth_sb_ctrl_wr_en !== 1'b0) begin failures++; $display("FAIL wr_en_one_cycle got=%b exp=0", bus.o_eth_sb_ctrl_wr_en); end
      bus.wdata_resp = 1'b1;
      tick();
      bus.wdata_resp = 1'b0;
      checks++; if (bus.o_eth_sb_pready !== 1'b1 || bus.o_eth_sb_pslverr !== 1'b0) begin failures++; $display("FAIL wr_resp got=%b%b exp=10", bus.o_eth_sb_pready, bus.o_eth_sb_pslverr); end
      tick();
      idle_inputs();
      checks++; if (bus.o_eth_sb_pready !== 1'b0) begin failures++; $display("FAIL wr_complete_pready got=%b exp=0", bus.o_eth_sb_pready); end
      tick();
   endtask

   task automatic test_prdata();
      bus.i_eth_sb_ctrl_rdata = 32'h87654321;
      #1;
      checks++; if (bus.o_eth_sb_prdata !== 32'h87654321) begin failures++; $display("FAIL prdata_passthru got=%h exp=87654321", bus.o_eth_sb_prdata); end
      bus.i_eth_sb_ctrl_rdata = 32'h0;
   endtask

   task automatic test_read();
      bus.i_eth_sb_psel    = 1'b1;
      bus.i_eth_sb_penable = 1'b0;
      bus.i_eth_sb_pwrite  = 1'b0;
      bus.i_eth_sb_paddr   = 32'h10;
      tick();
      checks++; if (bus.o_eth_sb_ctrl_rd_en !== 1'b1 || bus.o_eth_sb_ctrl_wr_en !== 1'b0) begin failures++; $display("FAIL rd_en_pulse got=%b%b exp=10", bus.o_eth_sb_ctrl_rd_en, bus.o_eth_sb_ctrl_wr_en); end
      checks++; if (bus.o_eth_sb_ctrl_addr !== 32'h10) begin failures++; $display("FAIL rd_addr got=%h exp=10", bus.o_eth_sb_ctrl_addr); end
      tick();
      checks++; if (bus.o_eth_sb_ctrl_rd_en !== 1'b0) begin failures++; $display("FAIL rd_en_one_cycle got=%b exp=0", bus.o_eth_sb_ctrl_rd_en); end
      bus.rdata_resp          = 1'b1;
      bus.i_eth_sb_ctrl_rdata = 32'hCAFEF00D;
      tick();
      bus.rdata_resp = 1'b0;
      checks++; if (bus.o_eth_sb_pready !== 1'b1 || bus.o_eth_sb_pslverr !== 1'b0) begin failures++; $display("FAIL rd_resp got=%b%b exp=10", bus.o_eth_sb_pready, bus.o_eth_sb_pslverr); end
      checks++; if (bus.o_eth_sb_prdata !== 32'hCAFEF00D) begin failures++; $display("FAIL rd_prdata got=%h exp=cafef00d", bus.o_eth_sb_prdata); end
      tick();
      checks++; if (bus.o_eth_sb_pready !== 1'b1) begin failures++; $display("FAIL rd_resp_hold got=%b exp=1", bus.o_eth_sb_pready); end
      bus.i_eth_sb_penable = 1'b1;
      tick();
      idle_inputs();
      checks++; if (bus.o_eth_sb_pready !== 1'b0) begin failures++; $display("FAIL rd_complete_pready got=%b exp=0", bus.o_eth_sb_pready); end
      tick();
   endtask

   task automatic test_fuse_error();
      bus.fuse_enable = 1'b0;
      start_write(32'h20, 32'h55, 4'h3);
      tick();
      checks++; if (bus.o_eth_sb_ctrl_wr_en !== 1'b0) begin failures++; $display("FAIL fuse_no_wr_en got=%b exp=0", bus.o_eth_sb_ctrl_wr_en); end
      checks++; if (bus.o_eth_sb_pready !== 1'b1 || bus.o_eth_sb_pslverr !== 1'b1) begin failures++; $display("FAIL fuse_err_resp got=%b%b exp=11", bus.o_eth_sb_pready, bus.o_eth_sb_pslverr); end
      tick();
      idle_inputs();
      checks++; if (bus.o_eth_sb_pready !== 1'b0 || bus.o_eth_sb_pslverr !== 1'b0) begin failures++; $display("FAIL fuse_complete got=%b%b exp=00", bus.o_eth_sb_pready, bus.o_eth_sb_pslverr); end
      tick();
   endtask

   task automatic test_inv_addr();
      bus.i_eth_sb_psel    = 1'b1;
      bus.i_eth_sb_penable = 1'b1;
      bus.i_eth_sb_pwrite  = 1'b0;
      bus.i_eth_sb_paddr   = 32'h44;
      tick();
      tick();
      bus.i_eth_sb_ctrl_inv_addr = 1'b1;
      tick();
      bus.i_eth_sb_ctrl_inv_addr = 1'b0;
      checks++; if (bus.o_eth_sb_pready !== 1'b0) begin failures++; $display("FAIL inv_wait_pready got=%b exp=0", bus.o_eth_sb_pready); end
      bus.rdata_resp = 1'b1;
      tick();
      bus.rdata_resp = 1'b0;
      checks++; if (bus.o_eth_sb_pready !== 1'b1 || bus.o_eth_sb_pslverr !== 1'b1) begin failures++; $display("FAIL inv_addr_err got=%b%b exp=11", bus.o_eth_sb_pready, bus.o_eth_sb_pslverr); end
      tick();
      idle_inputs();
      tick();
   endtask

   task automatic test_stall();
      int stall_bad;
      stall_bad = 0;
      bus.fifo_full = 1'b1;
      start_write(32'h30, 32'hDEADBEEF, 4'h1);
      for (int i = 0; i < 5; i++) begin
         tick();
         if (bus.o_eth_sb_ctrl_wr_en !== 1'b0 || bus.o_eth_sb_pready !== 1'b0) stall_bad++;
      end
      checks++; if (stall_bad != 0) begin failures++; $display("FAIL stall_hold bad_cycles=%0d exp=0", stall_bad); end
      bus.fifo_full = 1'b0;
      tick();
      checks++; if (bus.o_eth_sb_ctrl_wr_en !== 1'b1 || bus.o_eth_sb_ctrl_wdata !== 32'hDEADBEEF) begin failures++; $display("FAIL stall_release got=%b/%h exp=1/deadbeef", bus.o_eth_sb_ctrl_wr_en, bus.o_eth_sb_ctrl_wdata); end
      tick();
      bus.wdata_resp = 1'b1;
      tick();
      bus.wdata_resp = 1'b0;
      tick();
      idle_inputs();
      tick();
   endtask

   task automatic test_timeout();
      int n;
      n = 0;
      start_write(32'h40, 32'h1, 4'hF);
      tick();
      while (n < 400) begin
         tick();
         n++;
         if (bus.o_eth_sb_pready === 1'b1) break;
      end
      checks++; if (n != 257) begin failures++; $display("FAIL timeout_latency got=%0d exp=257", n); end
      checks++; if (bus.o_eth_sb_pslverr !== 1'b1) begin failures++; $display("FAIL timeout_err got=%b exp=1", bus.o_eth_sb_pslverr); end
      tick();
      idle_inputs();
      tick();
   endtask

   task automatic test_resp_timeout_tie();
      int early;
      early = 0;
      start_write(32'h50, 32'h2, 4'hF);
      tick();
      for (int i = 0; i < 256; i++) begin
         tick();
         if (bus.o_eth_sb_pready !== 1'b0) early++;
      end
      checks++; if (early != 0) begin failures++; $display("FAIL tie_early_pready cycles=%0d exp=0", early); end
      bus.wdata_resp = 1'b1;
      tick();
      bus.wdata_resp = 1'b0;
      checks++; if (bus.o_eth_sb_pready !== 1'b1 || bus.o_eth_sb_pslverr !== 1'b0) begin failures++; $display("FAIL tie_resp_wins got=%b%b exp=10", bus.o_eth_sb_pready, bus.o_eth_sb_pslverr); end
      tick();
      idle_inputs();
      tick();
   endtask

   task automatic test_reset_mid();
      int spurious;
      spurious = 0;
      start_write(32'h60, 32'hA5A5A5A5, 4'hC);
      bus.i_eth_sb_ctrl_slverr = 1'b1;
      tick();
      tick();
      tick();
      rst = 1'b1;
      #1;
      checks++; if (bus.o_eth_sb_ctrl_addr !== 32'h0 || bus.o_eth_sb_ctrl_wdata !== 32'h0 || bus.o_eth_sb_ctrl_pstrb !== 4'h0) begin failures++; $display("FAIL midrst_latches got=%h/%h/%h exp=0", bus.o_eth_sb_ctrl_addr, bus.o_eth_sb_ctrl_wdata, bus.o_eth_sb_ctrl_pstrb); end
      checks++; if (bus.o_eth_sb_pready !== 1'b0 || bus.o_eth_sb_pslverr !== 1'b0 || bus.o_eth_sb_ctrl_wr_en !== 1'b0) begin failures++; $display("FAIL midrst_ctrl got=%b%b%b exp=000", bus.o_eth_sb_pready, bus.o_eth_sb_pslverr, bus.o_eth_sb_ctrl_wr_en); end
      idle_inputs();
      tick();
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (bus.o_eth_sb_pready !== 1'b0) spurious++;
      end
      checks++; if (spurious != 0) begin failures++; $display("FAIL midrst_no_resp cycles=%0d exp=0", spurious); end
      bus.i_eth_sb_psel    = 1'b1;
      bus.i_eth_sb_penable = 1'b1;
      bus.i_eth_sb_paddr   = 32'h70;
      tick();
      checks++; if (bus.o_eth_sb_ctrl_rd_en !== 1'b1 || bus.o_eth_sb_ctrl_addr !== 32'h70) begin failures++; $display("FAIL midrst_restart got=%b/%h exp=1/70", bus.o_eth_sb_ctrl_rd_en, bus.o_eth_sb_ctrl_addr); end
      tick();
      bus.rdata_resp = 1'b1;
      tick();
      bus.rdata_resp = 1'b0;
      checks++; if (bus.o_eth_sb_pready !== 1'b1 || bus.o_eth_sb_pslverr !== 1'b0) begin failures++; $display("FAIL midrst_clean_resp got=%b%b exp=10", bus.o_eth_sb_pready, bus.o_eth_sb_pslverr); end
      tick();
      idle_inputs();
      tick();
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst      = 1'b0;
      idle_inputs();
      test_reset();
      test_write();
      test_prdata();
      test_read();
      test_fuse_error();
      test_inv_addr();
      test_stall();
      test_timeout();
      test_resp_timeout_tie();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/eth_sb_apb_fsm.md
Name: eth_sb_apb_fsm

Overview:
- APB slave front-end for the Ethernet sideband (eth_sb) register space.
- Converts APB3/APB4 transfers into single-cycle write and read request pulses toward the sideband controller.
- Waits for the controller's response, then completes the APB transfer with PREADY and PSLVERR.
- Sits between the system APB fabric and the eth_sb controller/FIFO logic.

Parameters:
- ADDR_WIDTH, 32, APB and controller address width.
- DATA_WIDTH, 32, APB and controller data width.
- TIMEOUT_CYCLES, 256, number of cycles to wait for a controller response before forcing an error completion.

Ports:
- i_clk  in  1  system clock; all state changes on the rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_eth_sb_psel  in  1  APB select.
- i_eth_sb_penable  in  1  APB enable.
- i_eth_sb_pwrite  in  1  1 = write, 0 = read.
- i_eth_sb_paddr  in  ADDR_WIDTH  APB address.
- i_eth_sb_pwdata  in  DATA_WIDTH  APB write data.
- i_eth_sb_pstrb  in  4  APB byte strobes.
- o_eth_sb_pready  out  1  APB ready.
- o_eth_sb_pslverr  out  1  APB error, valid only while pready=1.
- o_eth_sb_prdata  out  DATA_WIDTH  APB read data.
- o_eth_sb_ctrl_wdata  out  DATA_WIDTH  latched write data to the controller.
- o_eth_sb_ctrl_addr  out  ADDR_WIDTH  latched address to the controller.
- o_eth_sb_ctrl_wr_en  out  1  one-cycle write request.
- o_eth_sb_ctrl_rd_en  out  1  one-cycle read request.
- o_eth_sb_ctrl_pstrb  out  4  latched strobes to the controller.
- i_eth_sb_ctrl_rdata  in  DATA_WIDTH  controller read data.
- i_eth_sb_ctrl_slverr  in  1  controller error, sampled while waiting.
- i_eth_sb_ctrl_inv_addr  in  1  controller invalid-address flag, sampled while waiting.
- wdata_resp  in  1  controller write-complete pulse.
- rdata_resp  in  1  controller read-complete pulse.
- fuse_enable  in  1  sideband access enabled by fuse; 0 = all accesses error.
- fifo_full  in  1  write path full; new writes stall.
- fifo_empty  in  1  read path empty; new reads stall.

Behaviour:
- Reset (i_reset=1, asynchronous): state=IDLE; every registered output = 0 (pready, pslverr, ctrl_wdata, ctrl_addr, ctrl_wr_en, ctrl_rd_en, ctrl_pstrb); timeout counter = 0.
- Reset asserted mid-transfer aborts the transfer; no response is issued.
- o_eth_sb_prdata is a combinational pass-through of i_eth_sb_ctrl_rdata. It follows the controller input with zero latency, in every state.
- States: IDLE, WR_REQ, RD_REQ, WR_WAIT, RD_WAIT, RESP. Outputs are Moore, registered.
- IDLE: when psel=1, act on the first cycle psel is seen; penable is not required, so setup and access phases may coincide.
  - fuse_enable=0: go to RESP with error=1.
  - pwrite=1 and fifo_full=0: latch paddr/pwdata/pstrb into the ctrl outputs; go to WR_REQ.
  - pwrite=0 and fifo_empty=0: latch paddr; go to RD_REQ.
  - Otherwise (FIFO stall): remain in IDLE with pready=0.
- WR_REQ: ctrl_wr_en=1 for exactly one cycle, visible the cycle after the request is sampled; then go to WR_WAIT.
- RD_REQ: ctrl_rd_en=1 for exactly one cycle; then go to RD_WAIT.
- WR_WAIT / RD_WAIT: on wdata_resp / rdata_resp respectively, go to RESP.
  - The error flag is set if ctrl_slverr or inv_addr is 1 in the response cycle, or in any cycle of the wait.
  - The timeout counter increments every wait cycle. At TIMEOUT_CYCLES-1 it forces RESP with error=1.
  - A response pulse and timeout in the same cycle: the response wins, and error takes its normal value.
- RESP: pready=1 and pslverr=error.
  - Held until the cycle in which psel=1 and penable=1 (the APB completion); then go to IDLE. Error and counter are cleared.
  - psel=0 while in RESP: drop the response and return to IDLE.
- pready=0 in every state other than RESP.
- Addresses and data are passed unmodified; no alignment or range check is done in this block.
- Only one outstanding transfer at a time.

Decomposition:
- Package eth_sb_pkg holds:
  - state enum eth_sb_apb_state_e (IDLE, WR_REQ, RD_REQ, WR_WAIT, RD_WAIT, RESP);
  - localparam STRB_WIDTH=4;
  - default ADDR_WIDTH and DATA_WIDTH constants.
- Single module; no sub-module needed. The timeout counter is inline.

Test Plan:
- Write: fuse_enable=1, psel=penable=pwrite=1, paddr=32'hAABBCCDD, pwdata=32'h12345678, pstrb=4'hF.
  -> Next cycle ctrl_wr_en=1 for one cycle, ctrl_addr=32'hAABBCCDD, ctrl_wdata=32'h12345678, ctrl_pstrb=4'hF.
  -> After wdata_resp pulse: pready=1, pslverr=0.
- Read data path: i_eth_sb_ctrl_rdata=32'h87654321 -> o_eth_sb_prdata=32'h87654321 in the same cycle, in any state.
- Read: pwrite=0, fifo_empty=0, paddr=32'h10 -> ctrl_rd_en one-cycle pulse; rdata_resp with rdata=32'hCAFEF00D -> pready=1, prdata=32'hCAFEF00D, pslverr=0.
- Errors:
  - fuse_enable=0 write -> no wr_en; pready=1 with pslverr=1.
  - inv_addr=1 during RD_WAIT -> pslverr=1.
- Stall and timeout:
  - fifo_full=1 write -> pready stays 0, no wr_en until fifo_full=0.
  - No wdata_resp for 256 cycles -> pready=1, pslverr=1.
- Reset mid WR_WAIT: assert i_reset -> all outputs 0 immediately; next transfer starts cleanly from IDLE.
